// File: rtl/contador_ud_ctrl_if.sv
// Request/step bundle between the seek/manual controller and its users.
// The counter value is fed back in on `count`.
interface contador_ud_ctrl_if #(
    parameter int W = 4
);
    logic         start;
    logic [W-1:0] target;
    logic         abort;
    logic         man_up;
    logic         man_down;
    logic [W-1:0] count;
    logic         up;
    logic         down;
    logic         busy;
    logic         done;

    modport master (
        output start, target, abort, man_up, man_down, count,
        input  up, down, busy, done
    );

    modport slave (
        input  start, target, abort, man_up, man_down, count,
        output up, down, busy, done
    );
endinterface

// File: rtl/contador_ud_ctrl.sv
// Up/down counter sequencer: prescaled seek toward a latched target,
// plus edge-detected manual step buttons honoured only while idle.
module contador_ud_ctrl #(
    parameter int W   = 4,
    parameter int DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    contador_ud_ctrl_if.slave  bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic {
        IDLE,
        SEEK
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0]  tgt_q, tgt_d;
    logic          mu_q, md_q;
    logic          up_q, up_d;
    logic          down_q, down_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rise_u, rise_d;

    assign rise_u = bus.man_up & ~mu_q;
    assign rise_d = bus.man_down & ~md_q;

    // History regs reset high so a button held through reset is not an edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pre_q   <= '0;
            tgt_q   <= '0;
            mu_q    <= 1'b1;
            md_q    <= 1'b1;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tgt_q   <= tgt_d;
            mu_q    <= bus.man_up;
            md_q    <= bus.man_down;
            up_q    <= up_d;
            down_q  <= down_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        tgt_d   = tgt_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tgt_d   = bus.target;
                    state_d = SEEK;
                    pre_d   = '0;
                end else if (rise_u ^ rise_d) begin
                    up_d   = rise_u;
                    down_d = rise_d;
                end
            end
            SEEK: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    pre_d   = '0;
                end else if (pre_q == PMAX) begin
                    pre_d = '0;
                    if (bus.count == tgt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (bus.count < tgt_q) begin
                        up_d = 1'b1;
                    end else begin
                        down_d = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pre_d   = '0;
            end
        endcase
        busy_d = (state_d == SEEK);
    end

    assign bus.up   = up_q;
    assign bus.down = down_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_contador_ud_ctrl.sv
// Bench for contador_ud_ctrl: behavioural counter plus a timing-rule
// reference model, directed scenarios and a randomized soak.
module tb_contador_ud_ctrl;
    localparam int W   = 4;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset;
    logic [W-1:0] cnt;

    contador_ud_ctrl_if #(.W(W)) bus ();

    contador_ud_ctrl #(.W(W), .DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.count = cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: cycles elapsed since the seek was accepted
    bit           m_busy;
    int           m_el;
    logic [W-1:0] m_tgt;
    bit           m_mu, m_md;
    bit           e_up, e_down, e_busy, e_done;

    int t0, n_up, n_dn, first_up, last_up, first_dn, done_at, busy_n;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit ru, rd;
        if (!reset) begin
            m_busy = 0; m_el = 0; m_tgt = '0;
            m_mu = 1; m_md = 1;
            e_up = 0; e_down = 0; e_done = 0;
        end else begin
            ru = bus.man_up && !m_mu;
            rd = bus.man_down && !m_md;
            e_up = 0; e_down = 0; e_done = 0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy = 1;
                    m_el   = 0;
                    m_tgt  = bus.target;
                end else if (ru != rd) begin
                    e_up   = ru;
                    e_down = rd;
                end
            end else if (bus.abort) begin
                m_busy = 0;
            end else begin
                m_el++;
                if (m_el % DIV == 0) begin
                    if (cnt == m_tgt) begin
                        m_busy = 0;
                        e_done = 1;
                    end else if (cnt < m_tgt) e_up = 1;
                    else e_down = 1;
                end
            end
            m_mu = bus.man_up;
            m_md = bus.man_down;
        end
        e_busy = m_busy;
    endtask

    // One clock: model, edge, counter update, compare
    task automatic cycle();
        logic pu, pd;
        pu = bus.up;
        pd = bus.down;
        model_step();
        @(posedge clk);
        #1;
        if (pu && !pd) cnt = cnt + 4'd1;
        else if (pd && !pu) cnt = cnt - 4'd1;
        cyc++;
        chk("up", int'(bus.up), int'(e_up));
        chk("down", int'(bus.down), int'(e_down));
        chk("busy", int'(bus.busy), int'(e_busy));
        chk("done", int'(bus.done), int'(e_done));
        chk("up_down_excl", int'(bus.up & bus.down), 0);
    endtask

    task automatic run_seek(input logic [W-1:0] c0, input logic [W-1:0] tg,
                            input int ab_at, input int md_at);
        int rel;
        cnt = c0;
        n_up = 0; n_dn = 0; first_up = -1; last_up = -1;
        first_dn = -1; done_at = -1; busy_n = 0;
        t0 = cyc;
        for (int r = 0; r < 80; r++) begin
            bus.start    = (r == 0 || r == 2);
            bus.target   = (r == 0) ? tg : W'($urandom);
            bus.abort    = (r == ab_at);
            bus.man_down = (md_at >= 0 && r >= md_at);
            cycle();
            rel = cyc - t0;
            if (bus.up) begin
                n_up++;
                if (first_up < 0) first_up = rel;
                last_up = rel;
            end
            if (bus.down) begin
                n_dn++;
                if (first_dn < 0) first_dn = rel;
            end
            if (bus.busy) busy_n++;
            if (bus.done) done_at = rel;
            if (bus.done || r == ab_at) break;
        end
        bus.start  = 0;
        bus.abort  = 0;
        bus.target = '0;
    endtask

    initial begin
        reset = 0;
        cnt = '0;
        bus.start = 0; bus.target = '0; bus.abort = 0;
        bus.man_up = 1; bus.man_down = 0;

        // Reset held with man_up pressed
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_up", int'(bus.up), 0);
            chk("rst_busy", int'(bus.busy), 0);
        end
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("held_no_up", int'(bus.up), 0);
        end
        bus.man_up = 0;
        cycle();

        // 3 -> 6 with a man_down press mid-seek
        run_seek(4'd3, 4'd6, -1, 6);
        chk("s1_nup", n_up, 3);
        chk("s1_first_up", first_up, 5);
        chk("s1_last_up", last_up, 13);
        chk("s1_done", done_at, 17);
        chk("s1_busy_n", busy_n, 16);
        chk("s1_ndn", n_dn, 0);
        chk("s1_cnt", int'(cnt), 6);
        bus.man_down = 0;
        cycle();

        // 9 -> 7, man_down rising together with start
        run_seek(4'd9, 4'd7, -1, 0);
        chk("s2_ndn", n_dn, 2);
        chk("s2_first_dn", first_dn, 5);
        chk("s2_done", done_at, 13);
        chk("s2_nup", n_up, 0);
        chk("s2_cnt", int'(cnt), 7);
        bus.man_down = 0;
        cycle();

        // Zero-step seek
        run_seek(4'd5, 4'd5, -1, -1);
        chk("s3_done", done_at, 5);
        chk("s3_pulses", n_up + n_dn, 0);

        // Abort at cycle 7, then immediate restart
        run_seek(4'd0, 4'd15, 7, -1);
        chk("s4_nup", n_up, 1);
        chk("s4_first_up", first_up, 5);
        chk("s4_busy_off", int'(bus.busy), 0);
        chk("s4_no_done", done_at, -1);
        chk("s4_cnt", int'(cnt), 1);
        run_seek(4'd1, 4'd2, -1, -1);
        chk("s5_first_up", first_up, 5);
        chk("s5_done", done_at, 9);
        chk("s5_cnt", int'(cnt), 2);

        // Manual steps in IDLE
        bus.man_up = 1;
        cycle();
        chk("man_up_pulse", int'(bus.up), 1);
        cycle();
        chk("man_up_held", int'(bus.up), 0);
        chk("man_cnt", int'(cnt), 3);
        bus.man_up = 0;
        cycle();
        bus.man_up = 1; bus.man_down = 1;
        cycle();
        chk("both_no_up", int'(bus.up), 0);
        chk("both_no_down", int'(bus.down), 0);
        bus.man_up = 0; bus.man_down = 0;
        cycle();
        bus.man_down = 1;
        cycle();
        chk("man_down_pulse", int'(bus.down), 1);
        bus.man_down = 0;
        cycle();

        // Randomized soak checked against the model every cycle
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 199) != 0);
            bus.start  = ($urandom_range(0, 7) == 0);
            bus.target = W'($urandom);
            bus.abort  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 5) == 0) bus.man_up = ~bus.man_up;
            if ($urandom_range(0, 5) == 0) bus.man_down = ~bus.man_down;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/contador_ud_ctrl.md
# contador_ud_ctrl

Sequencing controller for the W-bit up/down counter. It drives the counter's `up`/`down` step inputs and reads back its `count`. It has two request sources: an automatic seek, which steps the counter one unit per prescaler tick toward a latched target, and manual step buttons. It sits between board push-buttons or upstream logic and the counter instance, and owns every step pulse the counter receives.

## Interface
- `W`, 4: counter width; must match the controlled counter.
- `DIV`, 4: prescaler period in clk cycles between seek decisions; legal range DIV >= 2.

- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: seek request; sampled only in IDLE.
- `target` in W: seek destination; latched when `start` is accepted.
- `abort` in 1: cancels an active seek.
- `man_up` in 1: manual increment button, level input.
- `man_down` in 1: manual decrement button, level input.
- `count` in W: current value fed back from the counter.
- `up` out 1: one-cycle increment pulse to the counter.
- `down` out 1: one-cycle decrement pulse to the counter.
- `busy` out 1: high while a seek is active.
- `done` out 1: one-cycle pulse when a seek reaches its target.

## Operation
- States: IDLE, SEEK. All outputs are registered.
- Counter contract: the counter moves by exactly one step on the edge that ends a cycle in which `up` or `down` is high. `up` and `down` are never high together.
- IDLE, `start` = 1:
  - latch `target` into `tgt_q`;
  - go to SEEK;
  - clear the prescaler to 0.
- SEEK:
  - The prescaler counts 0..DIV-1 and wraps.
  - In the cycle where prescaler = DIV-1, compare `count` with `tgt_q`:
    - equal: go to IDLE and pulse `done`;
    - count < tgt_q: pulse `up`;
    - count > tgt_q: pulse `down`.
  - Seek moves linearly. It never exploits counter wrap-around.
- SEEK, `abort` = 1: go to IDLE next cycle. No `done`, no step pulse. Abort overrides a same-cycle compare.
- `start` in SEEK is ignored. `target` changes in SEEK are ignored because `tgt_q` is held.
- Manual steps:
  - The history registers `mu_q` and `md_q` sample `man_up` and `man_down` every cycle in every state.
  - A rising edge on one input, sampled in IDLE, produces one `up` or `down` pulse next cycle. Holding the button gives no further steps.
  - Rising edges on both inputs in the same cycle: no step.
  - Manual edges in SEEK are discarded. Releasing and re-pressing after the seek ends is required.
  - `start` and a manual edge in the same IDLE cycle: `start` wins and the manual edge is dropped.
- Reset (low at a clock edge, in any state, including mid-seek):
  - state = IDLE, prescaler = 0, `tgt_q` = 0;
  - `mu_q` = `md_q` = 1, so a button held through reset gives no step;
  - `up` = `down` = `busy` = `done` = 0.

## Timing
- Cycle 0: `start` is accepted in IDLE.
- Cycle 1: `busy` = 1, prescaler = 0.
- Compares occur at cycles k*DIV for k >= 1.
- The step pulse for compare k is high in cycle k*DIV+1.
- The counter value is updated by cycle k*DIV+2, which is no later than the next compare because DIV >= 2.
- Seek needing N steps: pulses at cycles k*DIV+1 for k = 1..N.
- Completion of that seek, at cycle (N+1)*DIV+1: `done` = 1, `busy` = 0, state = IDLE.
- Zero steps (count = target at start): `done` at cycle DIV+1.
- Abort sampled in cycle c: `busy` = 0, `up` = `down` = 0 in cycle c+1.
- Manual edge sampled in IDLE in cycle c: pulse in cycle c+1. Minimum spacing between accepted manual steps is 2 cycles.
- After `done` or abort, a new `start` is accepted in the very next cycle.

## Test plan
Bench uses a behavioural counter model, W = 4, DIV = 4.
- Reset held low 3 cycles with `man_up` = 1 -> `up`/`down`/`busy`/`done` = 0. After release, no `up` pulse while `man_up` is held.
- count = 3, `start` with `target` = 6 at cycle 0 -> `up` at cycles 5, 9, 13; `done` at 17; `busy` high cycles 1-16; `down` never high; final count = 6.
- count = 9, `target` = 7 -> `down` at cycles 5, 9; `done` at 13. Also count = 5, `target` = 5 -> `done` at cycle 5 with no pulses.
- count = 0, `target` = 15, `abort` at cycle 7 -> one `up` at 5; `busy` = 0 at 8; no `done`; count = 1. `start` at cycle 8 is accepted.
- Manual, in IDLE:
  - `man_up` rising -> exactly one `up` pulse the next cycle;
  - `man_up` and `man_down` rising together -> no pulse;
  - `man_down` rising during SEEK -> no extra `down` pulse and seek timing unchanged.
- `start` and `man_down` rising in the same IDLE cycle -> seek runs; no manual `down` pulse.
